// File: rtl/input_serial_to_parallel.sv
// input_serial_to_parallel: LSB-first serial-to-parallel receiver with frame-sync alignment.
// Samples one bit per CLK and rebuilds WIDTH_OUTPUT-bit words, tracking back-to-back frames.
//
// Optional feature macro: INPUT_S2P_PARITY_EN
//   When defined, each frame carries a trailing even-parity bit (FRAME_LEN = WIDTH_OUTPUT+1)
//   and parity_err pulses alongside data_valid on a parity mismatch.
//   When undefined, FRAME_LEN = WIDTH_OUTPUT and parity_err is constant 0.
//
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous reset, active-high, highest priority
//   serial_in    serial data bit, sampled every rising edge
//   sync_in      high in the cycle serial_in carries bit 0 of a frame
//   data_out     last completed word (bit i = i-th received bit)
//   data_valid   one-cycle pulse when data_out updates
//   frame_err    one-cycle pulse when sync arrives mid-frame
//   parity_err   one-cycle pulse on parity mismatch (feature only)
//   frame_count  completed-frame counter, saturating at all-ones

module input_serial_to_parallel #(
   parameter int WIDTH_OUTPUT = 128,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    serial_in,
   input  logic                    sync_in,
   output logic [WIDTH_OUTPUT-1:0] data_out,
   output logic                    data_valid,
   output logic                    frame_err,
   output logic                    parity_err,
   output logic [CNT_WIDTH-1:0]    frame_count
);

`ifdef INPUT_S2P_PARITY_EN
   localparam int FRAME_LEN = WIDTH_OUTPUT + 1;
`else
   localparam int FRAME_LEN = WIDTH_OUTPUT;
`endif

   localparam int            BW   = $clog2(FRAME_LEN);
   localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

   typedef enum logic {
      HUNT,
      RUN
   } state_t;

   state_t                  state_q;
   logic [BW-1:0]           cnt_q;
   logic [WIDTH_OUTPUT-1:0] sreg_q;

`ifdef INPUT_S2P_PARITY_EN
   // running XOR of the data bits of the current frame
   logic par_q;
`endif

   logic [WIDTH_OUTPUT-1:0] bit_vec;
   logic [WIDTH_OUTPUT-1:0] word_nxt;
   logic                    in_run;
   logic                    begin_frame;
   logic                    misalign;
   logic                    frame_end;
   logic                    mid_bit;

   // Shifting a one-hot copy of the bit lands it at position cnt_q;
   // at the parity position (cnt_q >= WIDTH_OUTPUT) it shifts out to 0.
   assign bit_vec  = {{(WIDTH_OUTPUT-1){1'b0}}, serial_in};
   assign word_nxt = sreg_q | (bit_vec << cnt_q);

   assign in_run = (state_q == RUN);

   // Bit 0 of a frame: sync while hunting, or any bit at a frame boundary
   // (an aligned sync at cnt_q == 0 is not an error).
   assign begin_frame = (!in_run && sync_in) ||
                        (in_run && (cnt_q == '0));

   // Sync mid-frame: drop the partial word and restart at bit 0.
   assign misalign = in_run && sync_in && (cnt_q != '0);

   assign frame_end = in_run && !sync_in && (cnt_q == LAST);

   assign mid_bit = in_run && !sync_in &&
                    (cnt_q != '0) && (cnt_q != LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= HUNT;
         cnt_q       <= '0;
         sreg_q      <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         frame_count <= '0;
`ifdef INPUT_S2P_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;

         unique case (1'b1)
            begin_frame: begin
               state_q <= RUN;
               sreg_q  <= bit_vec;
               cnt_q   <= BW'(1);
`ifdef INPUT_S2P_PARITY_EN
               par_q   <= serial_in;
`endif
            end

            misalign: begin
               frame_err <= 1'b1;
               sreg_q    <= bit_vec;
               cnt_q     <= BW'(1);
`ifdef INPUT_S2P_PARITY_EN
               par_q     <= serial_in;
`endif
            end

            frame_end: begin
`ifdef INPUT_S2P_PARITY_EN
               // current bit is the parity bit; it is checked, not stored
               data_out   <= sreg_q;
               parity_err <= par_q ^ serial_in;
`else
               data_out   <= word_nxt;
`endif
               data_valid <= 1'b1;
               cnt_q      <= '0;
               if (frame_count != '1) begin
                  frame_count <= frame_count + CNT_WIDTH'(1);
               end
            end

            mid_bit: begin
               sreg_q <= word_nxt;
               cnt_q  <= cnt_q + BW'(1);
`ifdef INPUT_S2P_PARITY_EN
               par_q  <= par_q ^ serial_in;
`endif
            end

            default: begin
               // hunting without sync: serial_in is ignored
            end
         endcase
      end
   end

endmodule
